hv_dac_scheduler: RTL and testbench



---
 rtl/hv_dac_pkg.sv | 29 ++
 rtl/hv_dac_spi_shifter.sv | 80 ++++++++
 rtl/hv_dac_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_hv_dac_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hv_dac_pkg.sv
// -----------------------------------------------------------------------------
// hv_dac_pkg
// Shared types and helpers for the HV bias DAC scheduler.
//   state_t      : scheduler FSM states
//   HV_FRAME_W   : SPI frame length in bits
//   build_frame  : packs {1'b0, ch[2:0], code[11:0]} into one SPI frame
// -----------------------------------------------------------------------------
package hv_dac_pkg;

    localparam int HV_FRAME_W    = 16;
    localparam int HV_CH_FIELD_W = 3;
    localparam int HV_CODE_W     = 12;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SHIFT,
        GAP,
        LDAC
    } state_t;

    function automatic logic [HV_FRAME_W-1:0] build_frame(
        input logic [HV_CH_FIELD_W-1:0] ch,
        input logic [HV_CODE_W-1:0]     code
    );
        return {1'b0, ch, code};
    endfunction

endpackage

// File: rtl/hv_dac_spi_shifter.sv
// -----------------------------------------------------------------------------
// hv_dac_spi_shifter
// Serialises one HV_FRAME_W-bit frame MSB first. On start the first SCLK
// falling edge happens together with din = frame MSB; din then changes on each
// falling edge and the DAC samples on the rising edge. Each SCLK phase lasts
// SCLK_DIV cycles. The frame ends with SCLK high; done is a one-cycle strobe
// aligned with the edge on which the last high phase completes.
// Ports:
//   dtc_clk, rst : clock, synchronous active-high reset
//   start        : load frame and begin shifting
//   frame        : frame to send
//   sclk, din    : SPI clock (idles high) and data
//   done         : high in the last cycle of the frame
// -----------------------------------------------------------------------------
module hv_dac_spi_shifter
    import hv_dac_pkg::*;
#(
    parameter int SCLK_DIV = 4
) (
    input  logic                  dtc_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [HV_FRAME_W-1:0] frame,
    output logic                  sclk,
    output logic                  din,
    output logic                  done
);

    localparam int HALF_W = $clog2(2 * HV_FRAME_W);

    logic                  active_q;
    logic [7:0]            div_q;
    logic [HALF_W-1:0]     half_q;
    logic [HV_FRAME_W-1:0] sh_q;
    logic                  div_wrap;
    logic                  last_half;

    assign div_wrap  = (div_q == 8'(SCLK_DIV - 1));
    assign last_half = (half_q == HALF_W'(2 * HV_FRAME_W - 1));
    assign done      = active_q && div_wrap && last_half;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge dtc_clk) begin
        if (rst) begin
            active_q <= 1'b0;
            sclk     <= 1'b1;
            din      <= 1'b0;
            sh_q     <= '0;
            div_q    <= '0;
            half_q   <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            sclk     <= 1'b0;
            din      <= frame[HV_FRAME_W-1];
            sh_q     <= {frame[HV_FRAME_W-2:0], 1'b0};
            div_q    <= '0;
            half_q   <= '0;
        end else if (active_q) begin
            if (div_wrap) begin
                div_q  <= '0;
                half_q <= half_q + 1'b1;
                // Even half-periods are SCLK low; their end is a rising edge.
                if (!half_q[0]) begin
                    sclk <= 1'b1;
                end else if (last_half) begin
                    active_q <= 1'b0;
                    din      <= 1'b0;
                end else begin
                    sclk <= 1'b0;
                    din  <= sh_q[HV_FRAME_W-1];
                    sh_q <= {sh_q[HV_FRAME_W-2:0], 1'b0};
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hv_dac_scheduler.sv
// -----------------------------------------------------------------------------
// hv_dac_scheduler
// Shadow register file for the HV bias DACs. Written codes are marked dirty
// and flushed round-robin over a shared SPI bus (one sync_b per DAC chip);
// a common active-low load strobe is pulsed once everything is flushed and an
// apply has been requested.
// Optional feature macro: HV_DAC_AUTO_LDAC_EN -- when defined, finishing a
// flush (GAP -> IDLE with nothing dirty) requests a load pulse automatically.
// Ports:
//   dtc_clk, rst            : clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data : shadow write (addr = chip*N_CH + ch)
//   apply_req               : request one load_b pulse
//   rd_addr, rd_data        : registered shadow readback, 1-cycle latency
//   hv_dac_sclk, hv_dac_din : SPI clock (idles high) and data
//   hv_dac_sync_b           : per-chip frame select, active low
//   hv_dac_load_b           : common LDAC, active low
//   busy                    : dirty entries, frame in flight or apply pending
// -----------------------------------------------------------------------------
module hv_dac_scheduler
    import hv_dac_pkg::*;
#(
    parameter int N_CHIPS  = 4,
    parameter int N_CH     = 8,
    parameter int CODE_W   = 12,
    parameter int SCLK_DIV = 4,
    parameter int CS_GAP   = 2,
    parameter int LDAC_W   = 4
) (
    input  logic                              dtc_clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [$clog2(N_CHIPS*N_CH)-1:0]   wr_addr,
    input  logic [CODE_W-1:0]                 wr_data,
    input  logic                              apply_req,
    input  logic [$clog2(N_CHIPS*N_CH)-1:0]   rd_addr,
    output logic [CODE_W-1:0]                 rd_data,
    output logic                              hv_dac_sclk,
    output logic                              hv_dac_din,
    output logic [N_CHIPS-1:0]                hv_dac_sync_b,
    output logic                              hv_dac_load_b,
    output logic                              busy
);

    localparam int N_ENT  = N_CHIPS * N_CH;
    localparam int ADDR_W = $clog2(N_ENT);
    localparam int CHIP_W = (N_CHIPS > 1) ? $clog2(N_CHIPS) : 1;
    localparam int CNT_W  = 16;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CODE_W-1:0]        shadow_q [N_ENT];
    logic [N_ENT-1:0]         dirty_q;
    logic [ADDR_W-1:0]        last_served_q;
    logic [ADDR_W-1:0]        pick_idx;
    logic                     pick_valid;
    logic [CHIP_W-1:0]        pick_chip, cur_chip_q, chip_d;
    logic [HV_CH_FIELD_W-1:0] pick_ch;
    logic [HV_FRAME_W-1:0]    pick_frame;
    logic                     apply_pending_q, apply_relatch_q;
    logic                     shift_start, shift_done;
    logic                     dirty_clr, apply_clr, auto_set;
    logic [N_CHIPS-1:0]       sync_b_q, sync_b_d;
    logic                     load_b_q, load_b_d;
    int                       cand;

    // ---------------------------------------------------------------- shadow
    // NOTE: the shadow array is reset explicitly because readback after reset
    // must return 0; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge dtc_clk) begin
        if (rst) begin
            for (int e = 0; e < N_ENT; e++) shadow_q[e] <= '0;
            dirty_q <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en) shadow_q[wr_addr] <= wr_data;
            // A write landing on the entry being cleared keeps it dirty.
            for (int e = 0; e < N_ENT; e++) begin
                if (wr_en && wr_addr == ADDR_W'(e))
                    dirty_q[e] <= 1'b1;
                else if (dirty_clr && pick_idx == ADDR_W'(e))
                    dirty_q[e] <= 1'b0;
            end
            rd_data <= shadow_q[rd_addr];
        end
    end

    // ------------------------------------------------------ round-robin pick
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 1; i <= N_ENT; i++) begin
            cand = int'(last_served_q) + i;
            if (cand >= N_ENT) cand = cand - N_ENT;
            if (!pick_valid && dirty_q[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = ADDR_W'(cand);
            end
        end
        pick_chip  = CHIP_W'(int'(pick_idx) / N_CH);
        pick_ch    = HV_CH_FIELD_W'(int'(pick_idx) % N_CH);
        pick_frame = build_frame(pick_ch, shadow_q[pick_idx]);
    end

    // ------------------------------------------------------------ FSM logic
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_start = 1'b0;
        dirty_clr   = 1'b0;
        apply_clr   = 1'b0;
        auto_set    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|dirty_q)             state_d = SELECT;
                else if (apply_pending_q) state_d = LDAC;
            end
            SELECT: begin
                if (pick_valid) begin
                    shift_start = 1'b1;
                    dirty_clr   = 1'b1;
                    state_d     = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (shift_done) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef HV_DAC_AUTO_LDAC_EN
                    // Flush complete: request the load pulse ourselves.
                    auto_set = !(|dirty_q) && !wr_en;
`else
                    auto_set = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LDAC: begin
                if (cnt_q == CNT_W'(LDAC_W - 1)) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    apply_clr = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin values are decoded from the next state and registered, so the board
    // pins change cleanly on the same edge as the state.
    always_comb begin
        chip_d   = (state_q == SELECT) ? pick_chip : cur_chip_q;
        sync_b_d = '1;
        if (state_d == SHIFT) begin
            for (int c = 0; c < N_CHIPS; c++)
                sync_b_d[c] = (chip_d != CHIP_W'(c));
        end
        load_b_d = (state_d != LDAC);
    end

    always_ff @(posedge dtc_clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            cur_chip_q      <= '0;
            last_served_q   <= '0;
            apply_pending_q <= 1'b0;
            apply_relatch_q <= 1'b0;
            sync_b_q        <= '1;
            load_b_q        <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sync_b_q <= sync_b_d;
            load_b_q <= load_b_d;
            if (shift_start) begin
                cur_chip_q    <= pick_chip;
                last_served_q <= pick_idx;
            end
            // A request seen while pulsing is held aside so it survives the
            // end-of-pulse clear and produces a second pulse.
            if (apply_clr) begin
                apply_pending_q <= apply_relatch_q | apply_req;
                apply_relatch_q <= 1'b0;
            end else begin
                if (apply_req || auto_set)          apply_pending_q <= 1'b1;
                if (apply_req && state_q == LDAC)   apply_relatch_q <= 1'b1;
            end
        end
    end

    hv_dac_spi_shifter #(
        .SCLK_DIV (SCLK_DIV)
    ) u_shifter (
        .dtc_clk (dtc_clk),
        .rst     (rst),
        .start   (shift_start),
        .frame   (pick_frame),
        .sclk    (hv_dac_sclk),
        .din     (hv_dac_din),
        .done    (shift_done)
    );

    assign hv_dac_sync_b = sync_b_q;
    assign hv_dac_load_b = load_b_q;
    assign busy          = (state_q != IDLE) || (|dirty_q) || apply_pending_q;

endmodule

// File: tb/tb_hv_dac_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hv_dac_scheduler
// Self-checking bench for hv_dac_scheduler. Expected SPI frames are queued when
// writes are driven; a pin monitor decodes each frame and compares it against
// the queue head (chip, bits, length, SCLK rising edges, pin invariants).
// -----------------------------------------------------------------------------
module tb_hv_dac_scheduler;

    localparam int N_CHIPS   = 4;
    localparam int N_CH      = 8;
    localparam int CODE_W    = 12;
    localparam int SCLK_DIV  = 4;
    localparam int CS_GAP    = 2;
    localparam int LDAC_W    = 4;
    localparam int ADDR_W    = $clog2(N_CHIPS * N_CH);
    localparam int FRAME_CYC = 32 * SCLK_DIV;
`ifdef HV_DAC_AUTO_LDAC_EN
    localparam int AUTO = 1;
`else
    localparam int AUTO = 0;
`endif

    logic                dtc_clk = 1'b0;
    logic                rst = 1'b0;
    logic                wr_en = 1'b0;
    logic [ADDR_W-1:0]   wr_addr = '0;
    logic [CODE_W-1:0]   wr_data = '0;
    logic                apply_req = 1'b0;
    logic [ADDR_W-1:0]   rd_addr = '0;
    logic [CODE_W-1:0]   rd_data;
    logic                hv_dac_sclk, hv_dac_din, hv_dac_load_b, busy;
    logic [N_CHIPS-1:0]  hv_dac_sync_b;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          chip;
        logic [15:0] frame;
    } exp_t;
    exp_t sb[$];

    always #5 dtc_clk = ~dtc_clk;

    hv_dac_scheduler #(
        .N_CHIPS (N_CHIPS), .N_CH (N_CH), .CODE_W (CODE_W),
        .SCLK_DIV (SCLK_DIV), .CS_GAP (CS_GAP), .LDAC_W (LDAC_W)
    ) dut (
        .dtc_clk       (dtc_clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .apply_req     (apply_req),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .hv_dac_sclk   (hv_dac_sclk),
        .hv_dac_din    (hv_dac_din),
        .hv_dac_sync_b (hv_dac_sync_b),
        .hv_dac_load_b (hv_dac_load_b),
        .busy          (busy)
    );

    // ------------------------------------------------------------- monitor
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          expect_abort = 1'b0;
    bit          in_frame = 1'b0;
    bit          fr_bad;
    int          fr_chip, fr_len, fr_rises;
    logic [15:0] fr_bits;
    logic        prev_sclk = 1'b1;
    int          last_rise_cyc = 0;
    bit          have_rise = 1'b0;
    int          ld_run = 0;
    int          ldac_pulses = 0;
    int          ld_fall_cyc = 0;

    always @(posedge dtc_clk) cyc++;

    always @(negedge dtc_clk) begin
        if (mon_en) begin
            // load_b pulse width
            if (hv_dac_load_b === 1'b0) begin
                if (ld_run == 0) ld_fall_cyc = cyc;
                ld_run++;
            end else if (ld_run != 0) begin
                ldac_pulses++;
                vectors++;
                if (ld_run != LDAC_W) begin
                    miscompares++;
                    $display("FAIL ldac_width: got %0d cycles, required %0d", ld_run, LDAC_W);
                end
                ld_run = 0;
            end
            // SPI frame decode
            if (hv_dac_sync_b !== '1) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    fr_bits  = '0;
                    fr_len   = 0;
                    fr_rises = 0;
                    fr_bad   = 1'b0;
                    fr_chip  = -1;
                    for (int c = 0; c < N_CHIPS; c++)
                        if (hv_dac_sync_b[c] === 1'b0) fr_chip = c;
                    if (have_rise) begin
                        vectors++;
                        if (cyc - last_rise_cyc < CS_GAP + 2) begin
                            miscompares++;
                            $display("FAIL cs_gap: got %0d cycles, required >= %0d",
                                     cyc - last_rise_cyc, CS_GAP + 2);
                        end
                    end
                end
                fr_len++;
                if ($countones(~hv_dac_sync_b) != 1) fr_bad = 1'b1;
                if (hv_dac_load_b !== 1'b1) fr_bad = 1'b1;
                if (prev_sclk === 1'b0 && hv_dac_sclk === 1'b1) begin
                    fr_bits = {fr_bits[14:0], hv_dac_din};
                    fr_rises++;
                end
            end else if (in_frame) begin
                in_frame = 1'b0;
                if (expect_abort) begin
                    have_rise = 1'b0;
                end else begin
                    last_rise_cyc = cyc;
                    have_rise     = 1'b1;
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL frame_unexpected: got chip %0d frame %h, required none",
                                 fr_chip, fr_bits);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (fr_bits !== e.frame || fr_chip != e.chip || fr_len != FRAME_CYC ||
                            fr_rises != 16 || fr_bad) begin
                            miscompares++;
                            $display("FAIL frame: got chip %0d frame %h len %0d rises %0d bad %0b, required chip %0d frame %h len %0d rises 16 bad 0",
                                     fr_chip, fr_bits, fr_len, fr_rises, fr_bad,
                                     e.chip, e.frame, FRAME_CYC);
                        end
                    end
                end
            end
        end
        prev_sclk = hv_dac_sclk;
    end

    // ------------------------------------------------------------- helpers
    task automatic push_exp(input int idx, input logic [11:0] code);
        exp_t e;
        e.chip  = idx / N_CH;
        e.frame = {1'b0, 3'(idx % N_CH), code};
        sb.push_back(e);
    endtask

    task automatic do_write(input int addr, input logic [11:0] data);
        @(negedge dtc_clk);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        @(negedge dtc_clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge dtc_clk);
            if (busy === 1'b0) done = 1'b1;
        end
        @(negedge dtc_clk);
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", tag, busy, budget);
        end
    endtask

    task automatic wait_sync_low(input int chip, input int budget, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge dtc_clk);
            if (hv_dac_sync_b[chip] === 1'b0) done = 1'b1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s_sync_timeout: sync_b=%b, required bit %0d low", tag, hv_dac_sync_b, chip);
        end
    endtask

    task automatic check_exp_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", tag, got, want);
        end
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge dtc_clk);
        vectors += 6;
        if (hv_dac_sclk !== 1'b1)   begin miscompares++; $display("FAIL rst_sclk: got %b, required 1", hv_dac_sclk); end
        if (hv_dac_din !== 1'b0)    begin miscompares++; $display("FAIL rst_din: got %b, required 0", hv_dac_din); end
        if (hv_dac_sync_b !== '1)   begin miscompares++; $display("FAIL rst_sync_b: got %b, required all 1", hv_dac_sync_b); end
        if (hv_dac_load_b !== 1'b1) begin miscompares++; $display("FAIL rst_load_b: got %b, required 1", hv_dac_load_b); end
        if (busy !== 1'b0)          begin miscompares++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (rd_data !== '0)         begin miscompares++; $display("FAIL rst_rd_data: got %h, required 0", rd_data); end
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_single_write();
        int p0 = ldac_pulses;
        push_exp(0, 12'h033);
        do_write(0, 12'h033);
        @(negedge dtc_clk);
        vectors++;
        if (hv_dac_sync_b !== '1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_select: got sync_b %b busy %b, required 1111 1", hv_dac_sync_b, busy);
        end
        @(negedge dtc_clk);
        vectors++;
        if (hv_dac_sync_b !== 4'b1110 || hv_dac_sclk !== 1'b0 || hv_dac_din !== 1'b0) begin
            miscompares++;
            $display("FAIL single_start: got sync_b %b sclk %b din %b, required 1110 0 0",
                     hv_dac_sync_b, hv_dac_sclk, hv_dac_din);
        end
        wait_idle(400, "single");
        check_exp_val("single_ldac_count", 32'(ldac_pulses - p0), 32'(AUTO));
        check_exp_val("single_sb_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic test_back_to_back();
        int p0 = ldac_pulses;
        push_exp(1, 12'h077);
        push_exp(9, 12'h099);
        push_exp(17, 12'h0F0);
        @(negedge dtc_clk); wr_en = 1'b1; wr_addr = 5'd1;  wr_data = 12'h077;
        @(negedge dtc_clk);               wr_addr = 5'd9;  wr_data = 12'h099;
        @(negedge dtc_clk);               wr_addr = 5'd17; wr_data = 12'h0F0;
        @(negedge dtc_clk); wr_en = 1'b0; apply_req = 1'b1;
        @(negedge dtc_clk); apply_req = 1'b0;
        wait_idle(1500, "b2b");
        check_exp_val("b2b_ldac_count", 32'(ldac_pulses - p0), 32'd1);
        vectors++;
        if (ld_fall_cyc <= last_rise_cyc) begin
            miscompares++;
            $display("FAIL b2b_ldac_order: got load fall at %0d, required after sync rise at %0d",
                     ld_fall_cyc, last_rise_cyc);
        end
        check_exp_val("b2b_sb_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic test_rewrite_midshift();
        int p0 = ldac_pulses;
        push_exp(1, 12'h055);
        push_exp(1, 12'hABC);
        do_write(1, 12'h055);
        wait_sync_low(0, 10, "rewrite");
        repeat (40) @(negedge dtc_clk);
        do_write(1, 12'hABC);
        check_exp_val("rewrite_still_shifting", 32'(hv_dac_sync_b), 32'hE);
        wait_idle(1000, "rewrite");
        check_exp_val("rewrite_ldac_count", 32'(ldac_pulses - p0), 32'(AUTO));
        check_exp_val("rewrite_sb_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic test_readback();
        @(negedge dtc_clk); rd_addr = 5'd9;
        @(negedge dtc_clk);
        check_exp_val("rd_entry9", 32'(rd_data), 32'h099);
        rd_addr = 5'd17;
        @(negedge dtc_clk);
        check_exp_val("rd_entry17", 32'(rd_data), 32'h0F0);
        rd_addr = 5'd1;
        @(negedge dtc_clk);
        check_exp_val("rd_entry1", 32'(rd_data), 32'hABC);
        vectors++;
        if (hv_dac_sync_b !== '1 || hv_dac_sclk !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_pins_quiet: got sync_b %b sclk %b busy %b, required 1111 1 0",
                     hv_dac_sync_b, hv_dac_sclk, busy);
        end
    endtask

    task automatic test_apply();
        int  p0 = ldac_pulses;
        bit  seen = 1'b0;
        @(negedge dtc_clk); apply_req = 1'b1;
        @(negedge dtc_clk); apply_req = 1'b1;
        @(negedge dtc_clk); apply_req = 1'b0;
        wait_idle(100, "apply_merge");
        check_exp_val("apply_merge_count", 32'(ldac_pulses - p0), 32'd1);
        p0 = ldac_pulses;
        @(negedge dtc_clk); apply_req = 1'b1;
        @(negedge dtc_clk); apply_req = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge dtc_clk);
            if (hv_dac_load_b === 1'b0) seen = 1'b1;
        end
        check_exp_val("apply_pulse_seen", 32'(seen), 32'd1);
        apply_req = 1'b1;
        @(negedge dtc_clk); apply_req = 1'b0;
        wait_idle(100, "apply_relatch");
        check_exp_val("apply_relatch_count", 32'(ldac_pulses - p0), 32'd2);
    endtask

    task automatic test_reset_midframe();
        expect_abort = 1'b1;
        do_write(1, 12'h3C3);
        wait_sync_low(0, 10, "midrst");
        repeat (30) @(negedge dtc_clk);
        rst = 1'b1;
        @(negedge dtc_clk);
        vectors++;
        if (hv_dac_sync_b !== '1 || hv_dac_sclk !== 1'b1 || busy !== 1'b0 ||
            hv_dac_load_b !== 1'b1 || hv_dac_din !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_pins: got sync_b %b sclk %b busy %b load_b %b din %b, required 1111 1 0 1 0",
                     hv_dac_sync_b, hv_dac_sclk, busy, hv_dac_load_b, hv_dac_din);
        end
        rst = 1'b0;
        rd_addr = 5'd1;
        @(negedge dtc_clk);
        check_exp_val("midrst_rd_entry1", 32'(rd_data), 32'h0);
        repeat (20) @(negedge dtc_clk);
        vectors++;
        if (hv_dac_sync_b !== '1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_no_resume: got sync_b %b busy %b, required 1111 0", hv_dac_sync_b, busy);
        end
        expect_abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_rewrite_midshift();
        test_readback();
        test_apply();
        test_reset_midframe();
        check_exp_val("final_sb_left", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete in time, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
